// File: rtl/ysyx_22041412_regfile_sb.sv
// Multi-port GPR file with same-cycle write bypass and a per-register pending
// scoreboard that drives per-read-port ready flags for decode hazard stalls.
module ysyx_22041412_regfile_sb #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_ready,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];
    logic [NREG-1:1] pend_q, pend_d;
    logic [NREG-1:0] pend_vec;
    logic [AW:0]     busy_q, busy_d;
    logic [NWR-1:0]  wr_eff;
    logic [NREG-1:0] wr_hit;

    logic [AW-1:0]   rd_a   [NRD];
    logic [NRD-1:0]  rd_hit;
    logic [XLEN-1:0] rd_byp [NRD];

    // Register 0 has no pending storage; it reads as never pending.
    assign pend_vec = {pend_q, 1'b0};
    assign busy_cnt = busy_q;

    // Array next state: ports applied in ascending order so the highest index wins.
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < NREG; r++) begin
            mem_d[r] = mem_q[r];
        end
        for (int j = 0; j < NWR; j++) begin
            wr_eff[j] = wr_en[j] && (wr_addr[j*AW +: AW] != '0);
        end
        for (int j = 0; j < NWR; j++) begin
            if (wr_eff[j]) begin
                wr_hit[wr_addr[j*AW +: AW]] = 1'b1;
                mem_d[wr_addr[j*AW +: AW]]  = wr_data[j*XLEN +: XLEN];
            end
        end
        mem_d[0]  = '0;
        wr_hit[0] = 1'b0;
    end

    // Pending next state: flush > issue > write-clear > hold.
    always_comb begin
        pend_d = pend_q;
        busy_d = '0;
        for (int r = 1; r < NREG; r++) begin
            if (flush) begin
                pend_d[r] = 1'b0;
            end else if (iss_en && (iss_addr == AW'(r))) begin
                pend_d[r] = 1'b1;
            end else if (wr_hit[r]) begin
                pend_d[r] = 1'b0;
            end
            busy_d = busy_d + (AW+1)'(pend_d[r]);
        end
    end

    always_comb begin
        rd_data  = '0;
        rd_ready = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_a[i]   = rd_addr[i*AW +: AW];
            rd_hit[i] = 1'b0;
            rd_byp[i] = '0;
            for (int j = 0; j < NWR; j++) begin
                if (wr_eff[j] && (wr_addr[j*AW +: AW] == rd_a[i])) begin
                    rd_hit[i] = 1'b1;
                    rd_byp[i] = wr_data[j*XLEN +: XLEN];
                end
            end
            if (rd_a[i] == '0) begin
                rd_data[i*XLEN +: XLEN] = '0;
            end else if (rd_hit[i]) begin
                rd_data[i*XLEN +: XLEN] = rd_byp[i];
            end else begin
                rd_data[i*XLEN +: XLEN] = mem_q[rd_a[i]];
            end
            rd_ready[i] = (rd_a[i] == '0) || !pend_vec[rd_a[i]] || rd_hit[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= '0;
            end
            pend_q <= '0;
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= mem_d[r];
            end
            pend_q <= pend_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: doc/ysyx_22041412_regfile_sb.md
# ysyx_22041412_regfile_sb

Parametrised multi-port integer register file with a per-register pending-write scoreboard. It is the next-generation GPR block for the ysyx_22041412 core. It serves NRD decode-stage read ports and NWR writeback ports, and gives decode a ready flag per read port so hazard stalls no longer need a separate tracker. Architectural register 0 is hardwired to zero and is never pending.

## Interface
Parameters:
- XLEN, 64, data width of each register
- NREG, 32, number of architectural registers (power of two, ≥ 2)
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- AW, $clog2(NREG), address width (derived; do not override)

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
- rd_ready  out  NRD  1 = port i data is architecturally final this cycle
- wr_en  in  NWR  write enable per port
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- iss_en  in  1  issue marks destination pending
- iss_addr  in  AW  destination register of issuing instruction
- flush  in  1  pipeline flush; clears every pending bit
- busy_cnt  out  AW+1  registered count of pending registers

## Operation
- Storage: NREG×XLEN array plus NREG pending bits. pending[0] is always 0 and is never stored.
- Write qualification: port j is effective when wr_en[j] is high and wr_addr[j] != 0. Writes to register 0 are dropped.
- Same-address write conflict: when two or more effective ports target the same register, the highest-index port wins. The lower ports' data is discarded for that register.
- Read data per port i:
  - rd_addr = 0 → 0.
  - Else, if any effective write targets rd_addr → winning wr_data (same-cycle bypass).
  - Else → array contents.
- rd_ready[i] = 1 when any of the following holds:
  - rd_addr = 0
  - pending[rd_addr] = 0
  - an effective write targets rd_addr this cycle
  
  It reflects state before the coming edge. A same-cycle iss_en does not lower it.
- Pending update at each edge, evaluated per register r, highest priority first:
  1. flush → pending[r] = 0 for all r. iss_en is ignored that cycle; writes still update the array.
  2. iss_en && iss_addr = r && r != 0 → pending[r] = 1. Issue beats a same-cycle write to r, because the new producer supersedes it.
  3. Any effective write to r → pending[r] = 0.
  4. Otherwise pending[r] holds.
- busy_cnt: registered popcount of the pending bits after the edge update. Range 0..NREG-1.
- Reset (rst low, asynchronous):
  - All array entries → 0.
  - All pending bits → 0.
  - busy_cnt → 0.
  
  While rst is low:
  - rd_data returns 0 for non-bypassed reads.
  - rd_ready is all-ones, since nothing is pending.
  - Writes and issues are ignored.
  
  Assertion mid-operation discards in-flight state immediately, without waiting for clk.

## Timing
- Read path: fully combinational, zero latency, from rd_addr, the wr_* inputs and the state registers.
- Write: visible on rd_data in the same cycle via bypass, and from the array from the cycle after the edge.
- Pending set or clear: takes effect at the edge. rd_ready changes in the following cycle.
- busy_cnt: updates one edge after the causing event. It never counts register 0.
- Simultaneous events on one register in a cycle:
  - Issue + write → pending stays or becomes 1; the array still takes the data.
  - Flush + issue → pending 0.
  - Two writes → highest port's data is stored, and pending clears.
- Reset release: the first edge with rst high performs normal updates. No extra idle cycle is required.

## Test plan
- Reset, then write x5 = 0x1122334455667788 on port 0. Same cycle: rd_addr0 = 5 → rd_data0 = 0x1122334455667788, rd_ready0 = 1. Next cycle, with no write → same value read from the array.
- Port 0 writes x7 = 0xAAAA and port 1 writes x7 = 0xBBBB in the same cycle. Bypass read and the following-cycle read both return 0xBBBB. Write x0 = 0xFFFF → reads of x0 return 0, and busy_cnt is unchanged.
- Issue x3 → next cycle busy_cnt = 1 and rd_ready for x3 = 0. A write to x3 = 0x42 arrives: rd_ready = 1 and rd_data = 0x42 in that cycle, then busy_cnt = 0 next cycle.
- Issue x9 and write x9 = 0x10 in the same cycle → next cycle pending[x9] = 1, rd_ready = 0, array x9 = 0x10. Issue x0 → busy_cnt stays 0.
- Issue x1, x2, x4 on consecutive cycles → busy_cnt = 3. Assert flush together with an issue of x6 → next cycle busy_cnt = 0 and every rd_ready = 1.
- With x10 = 0x55 and x11 pending, pull rst low between clock edges → immediately x10 reads 0, busy_cnt = 0, all rd_ready = 1. Release rst, then write x10 = 0x66 on the next edge → reads 0x66.
